slave_in_port: RTL
==================

# slave_in_port

Receive side of a slave port on the serial system bus. Accepts the valid/ready handshake from the granted master, deserialises the LSB-first address and data bit streams into parallel words, and issues a single-cycle write or read strobe to the slave's local memory. For reads it holds the bus stalled until the slave's response path reports the read data has been returned.

## Interface
- ADDR_LEN, 12, address bits received per transaction
- DATA_LEN, 8, data bits received per transaction (captured on writes, ignored on reads)

- clk  input  1  bus clock; all logic is on its rising edge
- reset  input  1  asynchronous, active-high; returns the block to IDLE immediately
- master_valid  input  1  master driving a transaction; must stay 1 for the whole transfer
- write_en  input  1  write transaction (sampled at handshake)
- read_en  input  1  read transaction (sampled at handshake)
- rx_address  input  1  serial address bit, LSB first
- rx_data  input  1  serial data bit, LSB first
- mem_ready  input  1  local memory able to accept a new request
- read_done  input  1  pulse from the slave response path: read data fully returned
- slave_ready  output  1  registered; slave can accept a handshake
- mem_addr  output  ADDR_LEN  received address; updated only at commit
- mem_wdata  output  DATA_LEN  received write data; updated only on write commit
- mem_wen  output  1  one-cycle write strobe
- mem_ren  output  1  one-cycle read strobe
- rx_done  output  1  one-cycle pulse, coincident with mem_wen/mem_ren

## Operation
- N = max(ADDR_LEN, DATA_LEN) bit cycles per transaction. Internal bit counter holds 0..N-1. Internal shift registers hold the partial address and data.
- Address bits at index ADDR_LEN and above are ignored. Data bits at index DATA_LEN and above are ignored.
- States: IDLE, RECEIVE, COMMIT, READ_WAIT.
- IDLE:
  - slave_ready <= mem_ready.
  - A handshake occurs at an edge where master_valid=1, registered slave_ready=1, and exactly one of write_en/read_en is 1.
  - At the handshake edge: capture bit 0 of rx_address and rx_data, latch the mode, set count <= 1, set slave_ready <= 0, go to RECEIVE.
  - master_valid=1 with write_en and read_en both 0 or both 1: no handshake; stay in IDLE.
- RECEIVE:
  - Each edge captures bit[count] of both streams and increments count.
  - At the edge that captures bit N-1: load mem_addr (and mem_wdata if write), assert rx_done plus mem_wen or mem_ren, go to COMMIT.
  - master_valid=0 at any edge in RECEIVE: abort. Go to IDLE, no strobe, mem_addr/mem_wdata unchanged, partial bits discarded.
- COMMIT:
  - Lasts one cycle; strobes and rx_done deassert at the next edge.
  - Write: go to IDLE. Read: go to READ_WAIT.
- READ_WAIT:
  - slave_ready held 0.
  - read_done=1: go to IDLE.
- slave_ready is 0 in every state except IDLE.

## Timing
- Reset values: slave_ready=0, mem_addr=0, mem_wdata=0, mem_wen=0, mem_ren=0, rx_done=0, state IDLE, count=0.
- First edge after reset: slave_ready <= mem_ready.
- Call the handshake edge H. Bit i is sampled at edge H+i, for i=0..N-1.
- mem_wen/mem_ren/rx_done are high for exactly one cycle, from edge H+N-1 to edge H+N.
- mem_addr/mem_wdata are valid from edge H+N-1 and held until the next commit.
- Write, back-to-back:
  - Edge H+N: state returns to IDLE, and slave_ready <= mem_ready is loaded.
  - slave_ready is therefore 1 from edge H+N+1, giving the earliest next handshake at H+N+1.
- Read:
  - Edge H+N: state goes to READ_WAIT.
  - read_done sampled 1 at edge R: IDLE at R, slave_ready=1 from edge R+1 (if mem_ready=1).
- read_done while not in READ_WAIT: ignored.
- mem_ready falling mid-transaction: no effect until the block returns to IDLE.
- master_valid and the last bit arriving at the same edge: commit proceeds.
- master_valid=0 at edge H+N-1: treated as abort; no commit.
- reset asserted mid-transaction: outputs take reset values asynchronously, including a strobe in flight; nothing is committed.

## Test plan
- Write, defaults (N=12):
  - Stimulus: handshake with write_en=1; address 12'hA5C and data 8'h3B streamed LSB first.
  - Required: mem_wen=1 and rx_done=1 for one cycle, starting at edge H+11; mem_addr=12'hA5C, mem_wdata=8'h3B; slave_ready=1 again at H+13.
- Read:
  - Stimulus: handshake with read_en=1, address 12'h0FF, data stream 8'hFF.
  - Required: mem_ren pulse at H+11, mem_addr=12'h0FF, mem_wdata unchanged from the previous write.
  - Then: slave_ready stays 0 for 10 cycles; read_done pulse -> slave_ready=1 on the following edge.
- Abort:
  - Stimulus: master_valid drops at H+5 during a write.
  - Required: no mem_wen, no rx_done; mem_addr/mem_wdata keep their previous values; block back in IDLE.
- Handshake qualification:
  - Stimulus: write_en=read_en=1 with master_valid=1. Then mem_ready=0 at a handshake attempt.
  - Required: no handshake in either case, slave_ready stays 1 and 0 respectively; with mem_ready=0, slave_ready=0 and the attempt is ignored.
- Reset mid-transfer:
  - Stimulus: reset pulsed asynchronously at H+7.
  - Required: all outputs go to reset values immediately; the next transaction (addr 12'h001, data 8'h80) commits correctly.
- Parameter sweep:
  - Stimulus: ADDR_LEN=4, DATA_LEN=8, addr 4'h9, data 8'hC3.
  - Required: commit at H+7; extra address bits ignored; mem_addr=4'h9, mem_wdata=8'hC3.

Source files
------------

// File: rtl/slave_in_port.sv
// Receive side of a serial-bus slave port: handshake, LSB-first address/data
// deserialisation, and a single-cycle write/read strobe to local memory.
module slave_in_port #(
  parameter int ADDR_LEN = 12,
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                master_valid,
  input  logic                write_en,
  input  logic                read_en,
  input  logic                rx_address,
  input  logic                rx_data,
  input  logic                mem_ready,
  input  logic                read_done,
  output logic                slave_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_wen,
  output logic                mem_ren,
  output logic                rx_done
);

  localparam int N  = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RECEIVE   = 2'd1;
  localparam logic [1:0] COMMIT    = 2'd2;
  localparam logic [1:0] READ_WAIT = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] count;
  logic          is_write;
  logic          handshake;
  logic          capture;
  logic          last_capture;

  // Both streams shift in from the top; after N shifts bit i sits at index i,
  // so the N-1 stored bits plus the incoming bit form the complete word.
  logic [N-2:0]  addr_sr;
  logic [N-2:0]  data_sr;
  logic [N-1:0]  addr_next;
  logic [N-1:0]  data_next;

  assign addr_next    = {rx_address, addr_sr};
  assign data_next    = {rx_data, data_sr};
  assign handshake    = (state == IDLE) && master_valid && slave_ready && (write_en ^ read_en);
  assign capture      = handshake || ((state == RECEIVE) && master_valid);
  assign last_capture = (state == RECEIVE) && master_valid && (count == LAST_BIT);

  always_comb begin
    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:      if (handshake) state_next = RECEIVE;
      RECEIVE: begin
        if (!master_valid)          state_next = IDLE;
        else if (count == LAST_BIT) state_next = COMMIT;
      end
      COMMIT:    state_next = is_write ? IDLE : READ_WAIT;
      READ_WAIT: if (read_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      is_write    <= 1'b0;
      addr_sr     <= '0;
      data_sr     <= '0;
      slave_ready <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wen     <= 1'b0;
      mem_ren     <= 1'b0;
      rx_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge values.
      state   <= state_next;
      mem_wen <= 1'b0;
      mem_ren <= 1'b0;
      rx_done <= 1'b0;

      // Ready is loaded on the very edge the block lands in IDLE, which allows
      // a back-to-back handshake one cycle after the commit cycle.
      slave_ready <= (state_next == IDLE) && mem_ready;

      if (capture) begin
        addr_sr <= addr_next[N-1:1];
        data_sr <= data_next[N-1:1];
      end

      if (handshake) begin
        is_write <= write_en;
        count    <= CW'(1);
      end else if (last_capture) begin
        count    <= '0;
        mem_addr <= addr_next[ADDR_LEN-1:0];
        rx_done  <= 1'b1;
        if (is_write) begin
          mem_wdata <= data_next[DATA_LEN-1:0];
          mem_wen   <= 1'b1;
        end else begin
          mem_ren   <= 1'b1;
        end
      end else if (capture) begin
        count <= count + 1'b1;
      end else if (state == RECEIVE) begin
        count <= '0;
      end
    end
  end

endmodule
